// File: rtl/spi_master.sv
// spi_master: mode-0 (CPOL=0, CPHA=0) SPI initiator.
// Sends one DATA_WIDTH-bit word MSB first and captures miso at the same time.
// Flow: IDLE -> SETUP (cs_n low, sclk idle) -> XFER (sclk toggling) -> HOLD -> IDLE.
// The cycle that ends HOLD raises cs_n, publishes rx_data and pulses done.
module spi_master #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    // SETUP and HOLD reuse one phase counter, so it is sized for the longer of the two.
    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int HC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W   = $clog2(DATA_WIDTH);

    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [HC_W-1:0] HALF_LAST  = HC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state;
    logic [PH_W-1:0]       ph_cnt;
    logic [HC_W-1:0]       half_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;

    // Transfer sequencer: all SPI pins and handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ph_cnt   <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The first bit goes out with cs_n so it has the whole setup time to settle.
                    if (start) begin
                        tx_shift <= tx_data;
                        mosi     <= tx_data[DATA_WIDTH-1];
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        ph_cnt   <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        ph_cnt   <= '0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        sclk     <= 1'b0;
                        state    <= XFER;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                XFER: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (!sclk) begin
                            // Rising sclk: the slave has held miso stable for a full half-period.
                            sclk     <= 1'b1;
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                // Last falling edge: keep mosi on the final bit through HOLD.
                                bit_cnt <= '0;
                                ph_cnt  <= '0;
                                state   <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + BC_W'(1);
                                tx_shift <= tx_shift << 1;
                                mosi     <= tx_shift[DATA_WIDTH-2];
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + HC_W'(1);
                    end
                end
                HOLD: begin
                    if (ph_cnt == HOLD_LAST) begin
                        ph_cnt  <= '0;
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        rx_data <= rx_shift;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized bench for spi_master.
// Instance "a" is 16-bit with CLK_DIV=2; instance "b" is 8-bit with CLK_DIV=1 in loopback.
// Expected words, latencies and edge counts come from the transfer rules, not from the RTL.
module tb_spi_master;

    localparam int W   = 16;
    localparam int DIV = 2;
    localparam int SET = 2;
    localparam int HLD = 2;
    localparam int N   = SET + 2 * W * DIV + HLD;   // 68
    localparam int WB  = 8;
    localparam int NB  = SET + 2 * WB * 1 + HLD;    // 20

    logic          clk = 1'b0;
    logic          rst, start, busy, done, sclk, cs_n, mosi, miso;
    logic [W-1:0]  tx_data, rx_data;
    logic          rst_b, start_b, busy_b, done_b, sclk_b, cs_n_b, mosi_b, miso_b;
    logic [WB-1:0] tx_b, rx_b;

    // Slave model: a shift register presenting its MSB on miso, advancing after every sclk rise.
    logic          loop;
    logic [W-1:0]  slv_sh;
    logic [W-1:0]  mosi_acc;
    logic [WB-1:0] mosi_b_acc;
    int            rises, rises_b, cs_viol, cyc, first_rise_b, last_rise_b;
    logic          sclk_prev, sclk_b_prev, mosi_prev;
    int            n_checks = 0;
    int            n_errors = 0;

    assign miso   = loop ? mosi : slv_sh[W-1];
    assign miso_b = mosi_b;

    spi_master #(.DATA_WIDTH(W), .CLK_DIV(DIV), .CS_SETUP(SET), .CS_HOLD(HLD)) dut_a (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
        .rx_data(rx_data), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_master #(.DATA_WIDTH(WB), .CLK_DIV(1), .CS_SETUP(SET), .CS_HOLD(HLD)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .tx_data(tx_b), .busy(busy_b), .done(done_b),
        .rx_data(rx_b), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor on the falling clk edge: counts sclk rises, records mosi at each rise.
    initial begin
        sclk_prev = 1'b0; sclk_b_prev = 1'b0; mosi_prev = 1'b0;
        rises = 0; rises_b = 0; cs_viol = 0; cyc = 0;
        mosi_acc = '0; mosi_b_acc = '0; slv_sh = '0;
        first_rise_b = 0; last_rise_b = 0;
    end

    always @(negedge clk) begin
        cyc++;
        if (sclk && !sclk_prev) begin
            rises++;
            mosi_acc = {mosi_acc[W-2:0], mosi};
            slv_sh   = slv_sh << 1;
            check("mosi_stable_at_rise", 32'(mosi), 32'(mosi_prev));
        end
        if (sclk_b && !sclk_b_prev) begin
            rises_b++;
            mosi_b_acc = {mosi_b_acc[WB-2:0], mosi_b};
            if (rises_b == 1) first_rise_b = cyc;
            last_rise_b = cyc;
        end
        if (sclk && cs_n) cs_viol++;
        if (sclk_b && cs_n_b) cs_viol++;
        sclk_prev   = sclk;
        sclk_b_prev = sclk_b;
        mosi_prev   = mosi;
    end

    task automatic wait_done_a(output int lat);
        lat = 0;
        while (!done && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One complete transfer on instance a; tx_data is scrambled right after acceptance.
    task automatic run_a(input logic [W-1:0] tx, input logic [W-1:0] slv, input logic lb);
        int lat;
        loop = lb; slv_sh = slv; tx_data = tx; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rises = 0; mosi_acc = '0;
        tx_data = ~tx;
        check("busy_on_accept", 32'(busy), 32'd1);
        check("cs_low_on_accept", 32'(cs_n), 32'd0);
        wait_done_a(lat);
        check("latency", 32'(lat), 32'(N));
        check("rx_data", 32'(rx_data), 32'(lb ? tx : slv));
        check("sclk_rises", 32'(rises), 32'(W));
        check("mosi_word", 32'(mosi_acc), 32'(tx));
        check("busy_in_done", 32'(busy), 32'd0);
        check("cs_high_in_done", 32'(cs_n), 32'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic run_b(input logic [WB-1:0] tx);
        int lat;
        tx_b = tx; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; rises_b = 0; mosi_b_acc = '0;
        lat = 0;
        while (!done_b && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b_latency", 32'(lat), 32'(NB));
        check("b_rx_data", 32'(rx_b), 32'(tx));
        check("b_sclk_rises", 32'(rises_b), 32'(WB));
        check("b_mosi_word", 32'(mosi_b_acc), 32'(tx));
        check("b_sclk_period", 32'(last_rise_b - first_rise_b), 32'(2 * (WB - 1)));
    endtask

    initial begin
        int lat, idle_bad, ndone, guard;
        logic [W-1:0] w [3];
        logic [W-1:0] tx_keep;

        rst = 1'b1; start = 1'b0; tx_data = '0; loop = 1'b1;
        rst_b = 1'b1; start_b = 1'b0; tx_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;

        // Loopback and fixed slave response.
        run_a(16'hA55A, 16'h0000, 1'b1);
        run_a(16'hFFFF, 16'h3C0F, 1'b0);
        for (int i = 0; i < 6; i++)
            run_a(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        // start held high for three back-to-back words.
        for (int k = 0; k < 3; k++) w[k] = 16'($urandom);
        loop = 1'b1; tx_data = w[0]; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            rises = 0; mosi_acc = '0;
            check("b2b_busy", 32'(busy), 32'd1);
            lat = 0; idle_bad = 0;
            while (!done && lat < 1000) begin
                @(posedge clk); #1;
                lat++;
                if (!done && !busy) idle_bad++;
            end
            check("b2b_latency", 32'(lat), 32'(N));
            check("b2b_rx_data", 32'(rx_data), 32'(w[k]));
            check("b2b_busy_gap", 32'(idle_bad), 32'd0);
            check("b2b_cs_high_in_done", 32'(cs_n), 32'd1);
            if (k < 2) tx_data = w[k + 1];
            else       start = 1'b0;
            @(posedge clk); #1;
            check("b2b_cs_after_done", 32'(cs_n), (k < 2) ? 32'd0 : 32'd1);
        end

        // start pulse and tx_data change while busy are ignored.
        tx_keep = 16'h1234;
        loop = 1'b1; tx_data = tx_keep; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1; tx_data = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done_a(lat);
        check("busy_start_latency", 32'(lat + 21), 32'(N));
        check("busy_start_rx", 32'(rx_data), 32'(tx_keep));
        ndone = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("busy_start_extra_done", 32'(ndone), 32'd0);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Reset in the middle of bit 7.
        loop = 1'b1; tx_data = 16'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rises = 0;
        guard = 0;
        while (rises < 7 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_rst_reached_bit7", 32'(rises), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_cs_n", 32'(cs_n), 32'd1);
        check("mid_rst_sclk", 32'(sclk), 32'd0);
        check("mid_rst_mosi", 32'(mosi), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        ndone = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);

        // rst and start together: rst wins.
        rst = 1'b1; start = 1'b1; tx_data = 16'hBEEF;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_cs_n", 32'(cs_n), 32'd1);
        run_a(16'($urandom), 16'($urandom), 1'b0);

        // 8-bit instance, sclk period of two clk cycles.
        run_b(8'h81);
        for (int i = 0; i < 3; i++) run_b(8'($urandom));

        check("sclk_high_while_cs_high", 32'(cs_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
